// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: write-side and status bundle of the configurable UART transmitter.
// master drives writes and parity sense; slave (the transmitter) drives status and tx.
interface uart_tx_cfg_if #(
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              parity_odd;
    logic              full;
    logic              empty;
    logic              busy;
    logic              done;
    logic              tx;

    modport master (
        output wr_en, wr_data, parity_odd,
        input  full, empty, busy, done, tx
    );

    modport slave (
        input  wr_en, wr_data, parity_odd,
        output full, empty, busy, done, tx
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with a small write FIFO, configurable width and stop bits.
// Define UART_TX_PARITY_EN to add a parity bit (sense chosen per frame by parity_odd).
module uart_tx_cfg #(
    parameter int DATA_W     = 8,
    parameter int DIV        = 16'd10417,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input logic          clk,
    input logic          arst,
    input logic          rst,
    uart_tx_cfg_if.slave bus
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int BW   = $clog2(DATA_W);
    localparam int DIVM = DIV - 1;
    localparam int LB   = DATA_W - 1;
    localparam int ONE  = 1;

    localparam logic [15:0]   DIV_M1    = DIVM[15:0];
    localparam logic [BW-1:0] LAST_BIT  = LB[BW-1:0];
    localparam logic [BW-1:0] BIT_ONE   = ONE[BW-1:0];
    localparam logic [PW-1:0] PTR_ONE   = ONE[PW-1:0];
    localparam logic [PW:0]   CNT_ONE   = ONE[PW:0];
    localparam logic [PW:0]   DEPTH_C   = FIFO_DEPTH[PW:0];
    localparam logic          LAST_STOP = (STOP_BITS == 2);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state, state_d;
    logic [15:0]       cnt, cnt_d;
    logic [DATA_W-1:0] shreg, shreg_d;
    logic [BW-1:0]     bit_idx, bit_d;
    logic              stop_idx, stop_d;
    logic              tx_q, tx_d;
    logic              tick, pop, push, done_w;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic [DATA_W-1:0] head;

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;
`else
    logic unused_parity;
    assign unused_parity = bus.parity_odd;
`endif

    assign bus.full  = (count == DEPTH_C);
    assign bus.empty = (count == '0);
    assign bus.busy  = (state != IDLE);
    assign bus.tx    = tx_q;
    assign bus.done  = done_w;

    assign head   = mem[rd_ptr];
    assign push   = bus.wr_en && !bus.full;
    assign tick   = (cnt == DIV_M1);
    assign done_w = (state == STOP) && (stop_idx == LAST_STOP) && tick;

    // FIFO storage; stale entries are harmless because pointers gate reads
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    // FIFO pointers and occupancy; a write into a full FIFO is dropped
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (!push && pop) count <= count - CNT_ONE;
        end
    end

    // Frame state register and registered tx line
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx_q     <= 1'b1;
        end else if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            shreg    <= shreg_d;
            bit_idx  <= bit_d;
            stop_idx <= stop_d;
            tx_q     <= tx_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity bit of the frame in flight, fixed when the byte is popped
    always_ff @(posedge clk or posedge arst) begin
        if (arst)     par_q <= 1'b0;
        else if (rst) par_q <= 1'b0;
        else          par_q <= par_d;
    end
`endif

    // Next state, shifter, baud counter and the tx level for the next cycle
    always_comb begin
        state_d = state;
        cnt_d   = (state == IDLE || tick) ? 16'd0 : cnt + 16'd1;
        shreg_d = shreg;
        bit_d   = bit_idx;
        stop_d  = (state == STOP) ? stop_idx : 1'b0;
        pop     = 1'b0;
        tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state)
            IDLE: begin
                if (!bus.empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d = shreg >> 1;
                    bit_d   = bit_idx + BIT_ONE;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop_idx == LAST_STOP) begin
                        if (!bus.empty) begin
                            pop     = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_d = stop_idx + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shreg_d = head;
`ifdef UART_TX_PARITY_EN
            par_d   = (^head) ^ bus.parity_odd;
`endif
        end

        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: randomized bench against a frame-level model of the transmitter.
// Instance a: 8 data bits, 1 stop, depth 4; instance b: 7 data bits, 2 stops, depth 2.
module tb_uart_tx_cfg;
    localparam int DIVT = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_ON = 1;
`else
    localparam int PAR_ON = 0;
`endif

    typedef int unsigned uq_t[$];

    logic clk  = 1'b0;
    logic arst = 1'b0;
    logic rst  = 1'b0;

    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_W(8)) a_if ();
    uart_tx_cfg_if #(.DATA_W(7)) b_if ();

    uart_tx_cfg #(
        .DATA_W(8), .DIV(DIVT), .FIFO_DEPTH(4), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .arst(arst), .rst(rst), .bus(a_if)
    );

    uart_tx_cfg #(
        .DATA_W(7), .DIV(DIVT), .FIFO_DEPTH(2), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .arst(arst), .rst(rst), .bus(b_if)
    );

    // fa/fb: queued bytes; sa/sb: remaining line levels of the frame, one per cycle
    uq_t fa, sa, fb, sb;
    int  n_chk  = 0;
    int  n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the model: queue semantics plus whole-frame bit lists
    task automatic model_edge(ref uq_t fq, ref uq_t sq, input int dw, input int stp,
                              input int depth, input logic we, input int unsigned wd,
                              input logic po, input logic r);
        int          pre;
        int unsigned b;
        int unsigned p;
        uq_t         bits;
        if (r) begin
            fq.delete();
            sq.delete();
            return;
        end
        pre = fq.size();
        if (sq.size() > 0) void'(sq.pop_front());
        if (sq.size() == 0 && pre > 0) begin
            b = fq.pop_front();
            p = 0;
            bits.push_back(0);
            for (int i = 0; i < dw; i++) begin
                bits.push_back((b >> i) & 32'd1);
                p = p ^ ((b >> i) & 32'd1);
            end
            if (PAR_ON == 1) bits.push_back(p ^ 32'(po));
            for (int s = 0; s < stp; s++) bits.push_back(1);
            foreach (bits[j])
                for (int k = 0; k < DIVT; k++) sq.push_back(bits[j]);
        end
        if (we && pre < depth) fq.push_back(wd & ((32'd1 << dw) - 32'd1));
    endtask

    task automatic cmp(input string n, input uq_t fq, input uq_t sq, input int depth,
                       input logic tx, input logic busy, input logic done,
                       input logic empty, input logic full);
        chk({n, ".tx"},    32'(tx),    (sq.size() == 0) ? 32'd1 : sq[0]);
        chk({n, ".busy"},  32'(busy),  32'(sq.size() != 0));
        chk({n, ".done"},  32'(done),  32'(sq.size() == 1));
        chk({n, ".empty"}, 32'(empty), 32'(fq.size() == 0));
        chk({n, ".full"},  32'(full),  32'(fq.size() == depth));
    endtask

    task automatic cmp_all();
        cmp("a", fa, sa, 4, a_if.tx, a_if.busy, a_if.done, a_if.empty, a_if.full);
        cmp("b", fb, sb, 2, b_if.tx, b_if.busy, b_if.done, b_if.empty, b_if.full);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(fa, sa, 8, 1, 4, a_if.wr_en, 32'(a_if.wr_data),
                   a_if.parity_odd, rst || arst);
        model_edge(fb, sb, 7, 2, 2, b_if.wr_en, 32'(b_if.wr_data),
                   b_if.parity_odd, rst || arst);
        @(negedge clk);
        cmp_all();
    endtask

    task automatic wr_a(input logic [7:0] d, input logic po);
        a_if.wr_en      = 1'b1;
        a_if.wr_data    = d;
        a_if.parity_odd = po;
        step();
        a_if.wr_en = 1'b0;
    endtask

    task automatic wr_b(input logic [6:0] d, input logic po);
        b_if.wr_en      = 1'b1;
        b_if.wr_data    = d;
        b_if.parity_odd = po;
        step();
        b_if.wr_en = 1'b0;
    endtask

    // Asynchronous reset between edges: outputs must clear with no clock edge
    task automatic pulse_arst();
        a_if.wr_en = 1'b0;
        b_if.wr_en = 1'b0;
        #2 arst = 1'b1;
        #1;
        fa.delete();
        sa.delete();
        fb.delete();
        sb.delete();
        cmp_all();
        #1 arst = 1'b0;
    endtask

    initial begin
        int rate;
        a_if.wr_en = 1'b0;
        a_if.wr_data = '0;
        a_if.parity_odd = 1'b0;
        b_if.wr_en = 1'b0;
        b_if.wr_data = '0;
        b_if.parity_odd = 1'b0;

        #1 arst = 1'b1;
        #1 cmp_all();
        @(negedge clk);
        arst = 1'b0;
        repeat (3) step();

        wr_a(8'h55, 1'b0);
        repeat (50) step();

        wr_a(8'h07, 1'b0);
        repeat (50) step();
        wr_a(8'h07, 1'b1);
        repeat (50) step();

        for (int i = 1; i <= 6; i++) begin
            a_if.wr_en      = 1'b1;
            a_if.wr_data    = 8'(i);
            a_if.parity_odd = 1'b0;
            step();
        end
        a_if.wr_en = 1'b0;
        repeat (5 * 44 + 20) step();

        wr_a(8'h5A, 1'b1);
        repeat (19) step();
        pulse_arst();
        repeat (10) step();
        wr_a(8'hA3, 1'b0);
        repeat (50) step();

        wr_b(7'h7F, 1'b0);
        repeat (55) step();
        wr_b(7'h2A, 1'b1);
        wr_b(7'h15, 1'b0);
        wr_b(7'h33, 1'b1);
        repeat (150) step();

        rst = 1'b1;
        a_if.wr_en = 1'b1;
        a_if.wr_data = 8'hFF;
        step();
        rst = 1'b0;
        a_if.wr_en = 1'b0;
        repeat (5) step();

        rate = 10;
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) rate = $urandom_range(0, 2) == 0 ? 1 : ($urandom_range(0, 1) == 0 ? 12 : 45);
            a_if.wr_en      = ($urandom_range(0, rate) == 0);
            a_if.wr_data    = 8'($urandom);
            a_if.parity_odd = 1'($urandom);
            b_if.wr_en      = ($urandom_range(0, rate) == 0);
            b_if.wr_data    = 7'($urandom);
            b_if.parity_odd = 1'($urandom);
            rst             = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 899) == 0) pulse_arst();
            step();
        end
        rst = 1'b0;
        a_if.wr_en = 1'b0;
        b_if.wr_en = 1'b0;
        repeat (400) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
